serdes_word_aligner: RTL and testbench
======================================

// Module: serdes_word_aligner
// PURPOSE
// Word-alignment controller downstream of the x10 input deserializer.
// Watches deserialized parallel words for a training pattern.
// Issues active-low bitslip pulses back to the deserializer until the pattern locks.
// Then forwards aligned words to the output serializer path.
// PARAMETERS
// WIDTH          10      deserialized word width (bits)
// TRAIN_PATTERN  10'h3E0 training word expected once aligned (WIDTH bits)
// MATCH_COUNT    4       consecutive valid matches required to declare lock (>=1)
// SLIP_WAIT      3       valid words ignored after each bitslip pulse (settling, >=1)
// MAX_SLIPS      20      slips attempted before declaring failure
// PORTS
// clk            in   1                    fabric word clock
// reset          in   1                    synchronous, active-high
// enable_n       in   1                    active-low enable; 1 = hold in IDLE
// ready_i        in   1                    deserializer lock/ready
// word_i         in   WIDTH                deserialized word
// word_valid_i   in   1                    word_i valid this cycle
// bitslip_ctrl_n out  1                    active-low one-cycle bitslip request to deserializer
// aligned_o      out  1                    lock achieved
// error_o        out  1                    alignment failed (MAX_SLIPS exhausted)
// slip_count_o   out  $clog2(MAX_SLIPS+1)  slips issued since leaving IDLE
// word_o         out  WIDTH                forwarded word (valid only while aligned)
// word_valid_o   out  1                    word_o valid
// BEHAVIOUR
// - Reset values: bitslip_ctrl_n=1, aligned_o=0, error_o=0, slip_count_o=0, word_o=0, word_valid_o=0.
// - Reset state: IDLE, match counter and wait counter cleared.
// - FSM states: IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL.
// - IDLE -> CHECK when enable_n=0 && ready_i=1. Clears slip_count_o.
// - CHECK, per word_valid_i cycle:
//   - word_i==TRAIN_PATTERN: match counter +1; reaching MATCH_COUNT -> LOCKED.
//   - Mismatch: clear match counter. If slip_count_o==MAX_SLIPS -> FAIL, else -> SLIP.
//   - Cycles without word_valid_i change nothing.
// - SLIP: lasts exactly 1 clk.
//   - bitslip_ctrl_n=0 (registered) during that clk; slip_count_o +1.
//   - Next state is WAIT.
// - WAIT: counts SLIP_WAIT valid words, discarding them; then -> CHECK with match counter=0.
// - LOCKED: aligned_o=1.
//   - word_o/word_valid_o = word_i/word_valid_i delayed by 1 clk (registered).
//   - Payload is not checked against the pattern.
// - FAIL: error_o=1, aligned_o=0, no further slips. Exits only via the global abort rule.
// - Global abort, any state except IDLE: ready_i=0 or enable_n=1 -> IDLE next clk.
//   - Clears aligned_o and error_o; word_valid_o=0 the same clk.
//   - slip_count_o holds its value until IDLE is re-exited.
// - Bitslip spacing: pulses are never adjacent; min spacing is SLIP_WAIT valid words + 2 clk.
// - word_valid_o=0 in every state except LOCKED.
// - Reset mid-SLIP: bitslip_ctrl_n returns to 1 next clk; no partial pulse extension.
// - slip_count_o saturates at MAX_SLIPS; never wraps.
// TESTING
// 1. Reset=1 for 5 clk with random word_i -> all outputs at reset values, bitslip_ctrl_n=1 throughout.
// 2. ready_i=1, enable_n=0, aligned stream 10'h3E0 every clk -> aligned_o=1 after 4 valid words,
//    slip_count_o=0, zero bitslip pulses.
// 3. Bench model rotates 10'h3E0 left by r=3 and undoes one rotation per bitslip pulse ->
//    exactly 3 single-cycle low pulses, then aligned_o=1, slip_count_o=3.
// 4. Stream constant 10'h000 -> 20 slips spaced >= SLIP_WAIT+2 apart, then error_o=1,
//    bitslip_ctrl_n stays 1.
// 5. While LOCKED, drive ready_i=0 for 1 clk -> aligned_o=0 and word_valid_o=0 next clk;
//    re-lock after ready_i=1 with slip_count_o restarting at 0.
// 6. LOCKED, payload 10'h155 then 10'h2AA with word_valid_i gaps ->
//    word_o/word_valid_o mirror the input 1 clk later, no slips issued.

Source files
------------

// File: rtl/serdes_word_aligner.sv
// Word-alignment controller: issues bitslip pulses to the deserializer until a
// training word is seen MATCH_COUNT times in a row, then forwards aligned words.
module serdes_word_aligner #(
    parameter int               WIDTH         = 10,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 'h3E0,
    parameter int               MATCH_COUNT   = 4,
    parameter int               SLIP_WAIT     = 3,
    parameter int               MAX_SLIPS     = 20,
    localparam int              SW            = $clog2(MAX_SLIPS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_n,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             word_valid_i,
    output logic             bitslip_ctrl_n,
    output logic             aligned_o,
    output logic             error_o,
    output logic [SW-1:0]    slip_count_o,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid_o
);
    localparam int MW = (MATCH_COUNT > 1) ? $clog2(MATCH_COUNT) : 1;
    localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
    localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_COUNT - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT - 1);
    localparam logic [SW-1:0] SLIP_MAX   = SW'(MAX_SLIPS);

    typedef enum logic [2:0] {IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL} state_t;

    state_t           r_state;
    logic [MW-1:0]    r_match;
    logic [WW-1:0]    r_wait;
    logic [SW-1:0]    r_slip;
    logic             r_bitslip_n;
    logic             r_aligned;
    logic             r_error;
    logic [WIDTH-1:0] r_word;
    logic             r_wvalid;

    wire w_abort = (r_state != IDLE) && (!ready_i || enable_n);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_match     <= '0;
            r_wait      <= '0;
            r_slip      <= '0;
            r_bitslip_n <= 1'b1;
            r_aligned   <= 1'b0;
            r_error     <= 1'b0;
            r_word      <= '0;
            r_wvalid    <= 1'b0;
        end else if (w_abort) begin
            // slip count is kept for inspection until IDLE is left again
            r_state     <= IDLE;
            r_match     <= '0;
            r_wait      <= '0;
            r_bitslip_n <= 1'b1;
            r_aligned   <= 1'b0;
            r_error     <= 1'b0;
            r_wvalid    <= 1'b0;
        end else begin
            r_bitslip_n <= 1'b1;
            r_wvalid    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!enable_n && ready_i) begin
                        r_state <= CHECK;
                        r_slip  <= '0;
                        r_match <= '0;
                    end
                end
                CHECK: begin
                    if (word_valid_i) begin
                        if (word_i == TRAIN_PATTERN) begin
                            if (r_match == MATCH_LAST) begin
                                r_state   <= LOCKED;
                                r_aligned <= 1'b1;
                                r_match   <= '0;
                            end else begin
                                r_match <= r_match + 1'b1;
                            end
                        end else begin
                            r_match <= '0;
                            if (r_slip == SLIP_MAX) begin
                                r_state <= FAIL;
                                r_error <= 1'b1;
                            end else begin
                                // pulse is registered so it is low for exactly the SLIP cycle
                                r_state     <= SLIP;
                                r_bitslip_n <= 1'b0;
                                r_slip      <= r_slip + 1'b1;
                            end
                        end
                    end
                end
                SLIP: begin
                    r_state <= WAIT;
                    r_wait  <= '0;
                end
                WAIT: begin
                    if (word_valid_i) begin
                        if (r_wait == WAIT_LAST) begin
                            r_state <= CHECK;
                            r_wait  <= '0;
                            r_match <= '0;
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    r_word   <= word_i;
                    r_wvalid <= word_valid_i;
                end
                FAIL:    r_state <= FAIL;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bitslip_ctrl_n = r_bitslip_n;
    assign aligned_o      = r_aligned;
    assign error_o        = r_error;
    assign slip_count_o   = r_slip;
    assign word_o         = r_word;
    assign word_valid_o   = r_wvalid;
endmodule

// File: tb/tb_serdes_word_aligner.sv
// Directed bench for serdes_word_aligner: a vector table for single-cycle
// behaviour plus sequences for slip-to-lock and slip exhaustion.
module tb_serdes_word_aligner;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable_n = 1'b1;
    logic       ready_i = 1'b0;
    logic [9:0] word_i = '0;
    logic       word_valid_i = 1'b0;
    logic       bitslip_ctrl_n;
    logic       aligned_o;
    logic       error_o;
    logic [4:0] slip_count_o;
    logic [9:0] word_o;
    logic       word_valid_o;

    int errors = 0;
    int checks = 0;

    serdes_word_aligner dut (
        .clk(clk), .reset(reset), .enable_n(enable_n), .ready_i(ready_i),
        .word_i(word_i), .word_valid_i(word_valid_i),
        .bitslip_ctrl_n(bitslip_ctrl_n), .aligned_o(aligned_o), .error_o(error_o),
        .slip_count_o(slip_count_o), .word_o(word_o), .word_valid_o(word_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en_n, rdy;
        logic [9:0] word;
        logic       vld;
        logic       bs_n, al, er;
        logic [4:0] slip;
        logic [9:0] wo;
        logic       wv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, en_n, rdy, input logic [9:0] w, input logic v,
                       input logic bs_n, al, er, input logic [4:0] slip,
                       input logic [9:0] wo, input logic wv);
        vec_t t;
        t.rst = rst; t.en_n = en_n; t.rdy = rdy; t.word = w; t.vld = v;
        t.bs_n = bs_n; t.al = al; t.er = er; t.slip = slip; t.wo = wo; t.wv = wv;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input bit ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] rotl(input logic [9:0] w, input int r);
        logic [9:0] x;
        x = w;
        for (int i = 0; i < r; i++) x = {x[8:0], x[9]};
        return x;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; enable_n = 1'b1; ready_i = 1'b0; word_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int r, pulses, adj, gap_min, last, extra;
        bit prev;
        logic [31:0] got, exp;

        //   rst en rdy word   v | bs al er slip wo    wv
        add(1, 1, 0, 10'h3A5, 1,  1, 0, 0, 0, 10'h000, 0);
        add(1, 0, 1, 10'h3E0, 1,  1, 0, 0, 0, 10'h000, 0);
        add(1, 0, 1, 10'h000, 1,  1, 0, 0, 0, 10'h000, 0);
        add(1, 1, 1, 10'h155, 0,  1, 0, 0, 0, 10'h000, 0);
        add(1, 0, 0, 10'h2AA, 1,  1, 0, 0, 0, 10'h000, 0);
        add(0, 0, 1, 10'h3E0, 1,  1, 0, 0, 0, 10'h000, 0); // IDLE->CHECK
        add(0, 0, 1, 10'h3E0, 1,  1, 0, 0, 0, 10'h000, 0); // match 1
        add(0, 0, 1, 10'h3E0, 1,  1, 0, 0, 0, 10'h000, 0); // match 2
        add(0, 0, 1, 10'h3E0, 0,  1, 0, 0, 0, 10'h000, 0); // gap
        add(0, 0, 1, 10'h3E0, 1,  1, 0, 0, 0, 10'h000, 0); // match 3
        add(0, 0, 1, 10'h3E0, 1,  1, 1, 0, 0, 10'h000, 0); // match 4 -> lock
        add(0, 0, 1, 10'h155, 1,  1, 1, 0, 0, 10'h155, 1);
        add(0, 0, 1, 10'h000, 0,  1, 1, 0, 0, 10'h000, 0);
        add(0, 0, 1, 10'h2AA, 1,  1, 1, 0, 0, 10'h2AA, 1);
        add(0, 0, 1, 10'h3FF, 0,  1, 1, 0, 0, 10'h3FF, 0);
        add(0, 0, 1, 10'h2AA, 1,  1, 1, 0, 0, 10'h2AA, 1);
        add(0, 0, 0, 10'h3E0, 1,  1, 0, 0, 0, 10'h2AA, 0); // ready drop
        add(0, 0, 1, 10'h3E0, 1,  1, 0, 0, 0, 10'h2AA, 0); // back to CHECK
        add(0, 0, 1, 10'h000, 1,  0, 0, 0, 1, 10'h2AA, 0); // SLIP
        add(0, 0, 1, 10'h000, 1,  1, 0, 0, 1, 10'h2AA, 0); // WAIT
        add(0, 1, 1, 10'h000, 1,  1, 0, 0, 1, 10'h2AA, 0); // abort, count held
        add(0, 1, 1, 10'h000, 1,  1, 0, 0, 1, 10'h2AA, 0);
        add(0, 0, 1, 10'h000, 1,  1, 0, 0, 0, 10'h2AA, 0); // count restarts
        add(0, 0, 1, 10'h000, 1,  0, 0, 0, 1, 10'h2AA, 0); // SLIP
        add(1, 0, 1, 10'h000, 1,  1, 0, 0, 0, 10'h000, 0); // reset mid-SLIP

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; enable_n = vecs[i].en_n; ready_i = vecs[i].rdy;
            word_i = vecs[i].word; word_valid_i = vecs[i].vld;
            @(posedge clk); #1;
            got = {bitslip_ctrl_n, aligned_o, error_o, slip_count_o, word_o, word_valid_o};
            exp = {vecs[i].bs_n, vecs[i].al, vecs[i].er, vecs[i].slip, vecs[i].wo, vecs[i].wv};
            check($sformatf("vec%0d", i), got == exp, int'(got), int'(exp));
        end

        // rotated stream, bench undoes one rotation per bitslip pulse
        do_reset();
        r = 3; pulses = 0; adj = 0; prev = 1'b1;
        enable_n = 1'b0; ready_i = 1'b1;
        for (int c = 0; c < 400 && !aligned_o; c++) begin
            @(negedge clk);
            word_i = rotl(10'h3E0, r); word_valid_i = 1'b1;
            @(posedge clk); #1;
            if (!bitslip_ctrl_n) begin
                pulses++;
                if (!prev) adj++;
                if (r > 0) r--;
            end
            prev = bitslip_ctrl_n;
        end
        check("rot_aligned", aligned_o == 1'b1, int'(aligned_o), 1);
        check("rot_pulses", pulses == 3, pulses, 3);
        check("rot_adjacent", adj == 0, adj, 0);
        check("rot_slip_count", slip_count_o == 5'd3, int'(slip_count_o), 3);

        // constant zero stream exhausts the slip budget
        do_reset();
        pulses = 0; adj = 0; prev = 1'b1; gap_min = 1000; last = -1;
        enable_n = 1'b0; ready_i = 1'b1; word_i = 10'h000; word_valid_i = 1'b1;
        for (int c = 0; c < 1000 && !error_o; c++) begin
            @(posedge clk); #1;
            if (!bitslip_ctrl_n) begin
                pulses++;
                if (!prev) adj++;
                if (last >= 0 && c - last < gap_min) gap_min = c - last;
                last = c;
            end
            prev = bitslip_ctrl_n;
        end
        check("fail_error", error_o == 1'b1, int'(error_o), 1);
        check("fail_pulses", pulses == 20, pulses, 20);
        check("fail_spacing", gap_min >= 5, gap_min, 5);
        check("fail_adjacent", adj == 0, adj, 0);
        check("fail_slip_count", slip_count_o == 5'd20, int'(slip_count_o), 20);
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (!bitslip_ctrl_n) extra++;
        end
        check("fail_no_more_slips", extra == 0, extra, 0);
        check("fail_held", {error_o, aligned_o, word_valid_o} == 3'b100,
              int'({error_o, aligned_o, word_valid_o}), 4);
        check("fail_count_sat", slip_count_o == 5'd20, int'(slip_count_o), 20);

        // abort out of FAIL
        @(negedge clk); enable_n = 1'b1;
        @(posedge clk); #1;
        check("fail_abort", error_o == 1'b0, int'(error_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
